// File: rtl/soc_debug_cmd_arbiter.sv
// Round-robin arbiter that lets four CPU debug requesters share one OCI monitor port.
// Each command passes IDLE -> ISSUE -> WAIT -> DONE and completes with a one-cycle done/err pulse.
module soc_debug_cmd_arbiter #(
  parameter int unsigned CMD_W   = 38,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         req,
  input  logic [4*CMD_W-1:0] req_cmd,
  output logic [3:0]         gnt,
  output logic [3:0]         done,
  output logic [3:0]         err,
  output logic               mon_valid,
  output logic [CMD_W-1:0]   mon_cmd,
  output logic [1:0]         mon_sel,
  input  logic               mon_accept,
  input  logic               mon_ready,
  input  logic               mon_error,
  output logic               busy
);

  localparam int unsigned N_REQ = 4;
  localparam int unsigned SEL_W = 2;
  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [N_REQ-1:0]   done_q, done_d;
  logic [N_REQ-1:0]   err_q, err_d;
  logic               mon_valid_q, mon_valid_d;
  logic [CMD_W-1:0]   mon_cmd_q, mon_cmd_d;
  logic [SEL_W-1:0]   mon_sel_q, mon_sel_d;
  logic               busy_q, busy_d;

  logic [CMD_W-1:0]   cmd_slot_c [N_REQ];
  logic               win_found_c;
  logic [SEL_W-1:0]   win_idx_c;
  logic [SEL_W-1:0]   cand_c;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slot
    assign cmd_slot_c[gi] = req_cmd[gi*CMD_W +: CMD_W];
  end

  // Round-robin search: first asserted request at ptr, ptr+1, ... (mod 4).
  always_comb begin
    win_found_c = 1'b0;
    win_idx_c   = '0;
    cand_c      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand_c = ptr_q + SEL_W'(k);
      if (!win_found_c && req[cand_c]) begin
        win_found_c = 1'b1;
        win_idx_c   = cand_c;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    gnt_d       = '0;
    done_d      = '0;
    err_d       = '0;
    mon_valid_d = mon_valid_q;
    mon_cmd_d   = mon_cmd_q;
    mon_sel_d   = mon_sel_q;

    unique case (state_q)
      ST_IDLE: begin
        if (win_found_c) begin
          gnt_d[win_idx_c] = 1'b1;
          mon_cmd_d        = cmd_slot_c[win_idx_c];
          mon_sel_d        = win_idx_c;
          mon_valid_d      = 1'b1;
          ptr_d            = win_idx_c + SEL_W'(1);
          state_d          = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (mon_accept) begin
          mon_valid_d = 1'b0;
          cnt_d       = '0;
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A completion strobe in the timeout cycle takes precedence over the timeout.
        if (mon_ready) begin
          done_d[mon_sel_q] = 1'b1;
          err_d[mon_sel_q]  = mon_error;
          state_d           = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          done_d[mon_sel_q] = 1'b1;
          err_d[mon_sel_q]  = 1'b1;
          state_d           = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      gnt_q       <= '0;
      done_q      <= '0;
      err_q       <= '0;
      mon_valid_q <= 1'b0;
      mon_cmd_q   <= '0;
      mon_sel_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      err_q       <= err_d;
      mon_valid_q <= mon_valid_d;
      mon_cmd_q   <= mon_cmd_d;
      mon_sel_q   <= mon_sel_d;
      busy_q      <= busy_d;
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign err       = err_q;
  assign mon_valid = mon_valid_q;
  assign mon_cmd   = mon_cmd_q;
  assign mon_sel   = mon_sel_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_soc_debug_cmd_arbiter.sv
// Scoreboard bench for soc_debug_cmd_arbiter: expected grants and completions are queued
// as stimulus is driven and popped by a negedge monitor when the DUT pulses gnt or done/err.
module tb_soc_debug_cmd_arbiter;

  localparam int unsigned CMD_W = 38;
  localparam int unsigned TMO   = 8;

  logic               clk;
  logic               reset;
  logic [3:0]         req;
  logic [4*CMD_W-1:0] req_cmd;
  logic [3:0]         gnt, done, err;
  logic               mon_valid;
  logic [CMD_W-1:0]   mon_cmd;
  logic [1:0]         mon_sel;
  logic               mon_accept, mon_ready, mon_error;
  logic               busy;

  typedef struct {
    int               w;
    logic [CMD_W-1:0] cmd;
  } gnt_exp_t;

  typedef struct {
    int w;
    bit e;
  } done_exp_t;

  gnt_exp_t  exp_g_q[$];
  done_exp_t exp_d_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int m_ptr    = 0;

  soc_debug_cmd_arbiter #(.CMD_W(CMD_W), .TIMEOUT(TMO)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_cmd   (req_cmd),
    .gnt       (gnt),
    .done      (done),
    .err       (err),
    .mon_valid (mon_valid),
    .mon_cmd   (mon_cmd),
    .mon_sel   (mon_sel),
    .mon_accept(mon_accept),
    .mon_ready (mon_ready),
    .mon_error (mon_error),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int rr_pick(input logic [3:0] r, input int p);
    int idx;
    for (int k = 0; k < 4; k++) begin
      idx = (p + k) % 4;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [CMD_W-1:0] rand_cmd();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[CMD_W-1:0];
  endfunction

  function automatic logic [3:0] onehot(input int w);
    logic [3:0] oh;
    logic [1:0] i2;
    oh = '0;
    i2 = 2'(w);
    oh[i2] = 1'b1;
    return oh;
  endfunction

  // Monitor: every gnt and every done/err pulse must match the head of its queue.
  always @(negedge clk) begin
    gnt_exp_t  g;
    done_exp_t d;
    if (gnt != 4'b0) begin
      if (exp_g_q.size() == 0) begin
        chk("unexp_gnt", 64'(gnt), 64'(0));
      end else begin
        g = exp_g_q.pop_front();
        chk("gnt", 64'(gnt), 64'(onehot(g.w)));
        chk("gnt_cmd", 64'(mon_cmd), 64'(g.cmd));
        chk("gnt_sel", 64'(mon_sel), 64'(g.w));
        chk("gnt_valid", 64'(mon_valid), 64'(1));
        chk("gnt_busy", 64'(busy), 64'(1));
      end
    end
    if (done != 4'b0 || err != 4'b0) begin
      if (exp_d_q.size() == 0) begin
        chk("unexp_done", 64'({done, err}), 64'(0));
      end else begin
        d = exp_d_q.pop_front();
        chk("done", 64'(done), 64'(onehot(d.w)));
        chk("err", 64'(err), d.e ? 64'(onehot(d.w)) : 64'(0));
      end
    end
  end

  task automatic apply_reset();
    reset = 1'b1;
    req   = '0;
    tick();
    tick();
    chk("rst_gnt", 64'(gnt), 64'(0));
    chk("rst_done", 64'({done, err}), 64'(0));
    chk("rst_valid", 64'(mon_valid), 64'(0));
    chk("rst_cmd", 64'(mon_cmd), 64'(0));
    chk("rst_sel", 64'(mon_sel), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    reset = 1'b0;
    m_ptr = 0;
  endtask

  // One full transaction; rdy_dly < 0 means mon_ready never comes (timeout).
  task automatic run_txn(input logic [3:0] rq, input bit hold, input int exp_glat,
                         input int acc_dly, input int rdy_dly, input bit merr,
                         input logic [3:0] stray, input bit use_ovr,
                         input logic [CMD_W-1:0] cmd_ovr);
    int w, glat, k, exp_lat;
    bit done_seen;
    logic [CMD_W-1:0] cmdw;
    gnt_exp_t  g;
    done_exp_t d;
    if (!hold) tick();
    for (int i = 0; i < 4; i++) req_cmd[i*CMD_W +: CMD_W] = rand_cmd();
    w = rr_pick(rq, m_ptr);
    if (use_ovr) req_cmd[w*CMD_W +: CMD_W] = cmd_ovr;
    cmdw  = req_cmd[w*CMD_W +: CMD_W];
    m_ptr = (w + 1) % 4;
    g.w = w; g.cmd = cmdw; exp_g_q.push_back(g);
    d.w = w; d.e = (rdy_dly < 0) ? 1'b1 : merr; exp_d_q.push_back(d);
    req = rq;

    glat = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      glat++;
      if (gnt != 4'b0) break;
    end
    chk("gnt_seen", 64'(gnt != 4'b0), 64'(1));
    if (exp_glat > 0) chk("gnt_lat", 64'(glat), 64'(exp_glat));
    if (!hold) req = '0;
    for (int i = 0; i < 4; i++) req_cmd[i*CMD_W +: CMD_W] = rand_cmd();

    // ISSUE: hold off mon_accept while a stray mon_ready must be ignored.
    for (int a = 0; a < acc_dly; a++) begin
      chk("iss_valid", 64'(mon_valid), 64'(1));
      chk("iss_cmd", 64'(mon_cmd), 64'(cmdw));
      chk("iss_sel", 64'(mon_sel), 64'(w));
      chk("iss_done", 64'(done), 64'(0));
      mon_ready = 1'b1;
      tick();
      mon_ready = 1'b0;
    end
    chk("acc_valid", 64'(mon_valid), 64'(1));
    chk("acc_cmd", 64'(mon_cmd), 64'(cmdw));
    mon_accept = 1'b1;
    tick();
    mon_accept = 1'b0;
    chk("wait_valid", 64'(mon_valid), 64'(0));
    chk("wait_busy", 64'(busy), 64'(1));

    done_seen = 1'b0;
    for (k = 0; k < int'(TMO) + 4; k++) begin
      if (k == 0 && !hold) req = stray;
      if (k == 1 && !hold) req = '0;
      mon_accept = (k == 0);
      if (k == rdy_dly) begin
        mon_ready = 1'b1;
        mon_error = merr;
      end
      tick();
      mon_ready  = 1'b0;
      mon_error  = 1'b0;
      mon_accept = 1'b0;
      if (done != 4'b0) begin
        done_seen = 1'b1;
        break;
      end
    end
    if (!hold) req = '0;
    exp_lat = (rdy_dly < 0) ? int'(TMO) : rdy_dly + 1;
    chk("done_seen", 64'(done_seen), 64'(1));
    chk("done_lat", 64'(k + 1), 64'(exp_lat));
    chk("done_busy", 64'(busy), 64'(1));
  endtask

  initial begin
    int w;
    gnt_exp_t g;
    reset      = 1'b1;
    req        = '0;
    req_cmd    = '0;
    mon_accept = 1'b0;
    mon_ready  = 1'b0;
    mon_error  = 1'b0;
    apply_reset();

    run_txn(4'b0100, 1'b0, 1, 0, 0, 1'b0, 4'b0000, 1'b1, 38'h2A5555AAAA);

    apply_reset();
    run_txn(4'b1111, 1'b1, 1, 0, 0, 1'b0, 4'b0000, 1'b0, '0);
    run_txn(4'b1111, 1'b1, 2, 0, 0, 1'b1, 4'b0000, 1'b0, '0);
    run_txn(4'b1111, 1'b1, 2, 0, 0, 1'b0, 4'b0000, 1'b0, '0);
    run_txn(4'b1111, 1'b1, 2, 0, 0, 1'b1, 4'b0000, 1'b0, '0);
    req = '0;

    run_txn(4'b1010, 1'b0, 1, 5, 2, 1'b1, 4'b0001, 1'b0, '0);
    run_txn(4'b0010, 1'b0, 1, 0, -1, 1'b0, 4'b0000, 1'b0, '0);
    run_txn(4'b1001, 1'b0, 1, 1, int'(TMO) - 1, 1'b1, 4'b0000, 1'b0, '0);
    run_txn(4'b0110, 1'b0, 1, 2, int'(TMO) - 1, 1'b0, 4'b1000, 1'b0, '0);

    // Monitor strobes while idle must not start or complete anything.
    tick();
    mon_ready  = 1'b1;
    mon_accept = 1'b1;
    mon_error  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_busy", 64'(busy), 64'(0));
      chk("idle_valid", 64'(mon_valid), 64'(0));
    end
    mon_ready  = 1'b0;
    mon_accept = 1'b0;
    mon_error  = 1'b0;

    // Reset while waiting for completion aborts silently and restarts the pointer.
    for (int i = 0; i < 4; i++) req_cmd[i*CMD_W +: CMD_W] = rand_cmd();
    w = rr_pick(4'b0010, m_ptr);
    g.w = w; g.cmd = req_cmd[w*CMD_W +: CMD_W]; exp_g_q.push_back(g);
    req = 4'b0010;
    tick();
    req = '0;
    chk("rw_gnt", 64'(gnt), 64'(4'b0010));
    mon_accept = 1'b1;
    tick();
    mon_accept = 1'b0;
    tick();
    chk("rw_busy", 64'(busy), 64'(1));
    reset     = 1'b1;
    mon_ready = 1'b1;
    tick();
    reset     = 1'b0;
    mon_ready = 1'b0;
    m_ptr     = 0;
    chk("rw_busy0", 64'(busy), 64'(0));
    chk("rw_done", 64'({done, err}), 64'(0));
    chk("rw_valid", 64'(mon_valid), 64'(0));
    chk("rw_cmd", 64'(mon_cmd), 64'(0));
    tick();
    chk("rw_done2", 64'({done, err}), 64'(0));
    run_txn(4'b1111, 1'b0, 1, 0, 1, 1'b0, 4'b0000, 1'b0, '0);

    tick();
    tick();
    chk("gq_empty", 64'(exp_g_q.size()), 64'(0));
    chk("dq_empty", 64'(exp_d_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/soc_debug_cmd_arbiter.md
SOC_DEBUG_CMD_ARBITER -- requirements
Module: soc_debug_cmd_arbiter

Interface
REQ-001 SHALL have parameter CMD_W, default 38, width of one debug command word (jdo format).
REQ-002 SHALL have parameter TIMEOUT, default 256, maximum WAIT-state cycles before forced error completion (legal range 2..65535).
REQ-003 SHALL have port clk  input  1  sole clock; all logic is rising-edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req  input  4  per-CPU command request, level; bit i belongs to requester i.
REQ-006 SHALL have port req_cmd  input  4*CMD_W  command words; requester i occupies bits [i*CMD_W +: CMD_W].
REQ-007 SHALL have port gnt  output  4  one-hot, one-cycle pulse; marks acceptance of a request and capture of its command.
REQ-008 SHALL have port done  output  4  one-hot, one-cycle completion pulse to the granted requester.
REQ-009 SHALL have port err  output  4  one-hot; pulses together with done when the completion is an error.
REQ-010 SHALL have port mon_valid  output  1  command presented to the shared OCI monitor port.
REQ-011 SHALL have port mon_cmd  output  CMD_W  captured command word.
REQ-012 SHALL have port mon_sel  output  2  index of the owning requester.
REQ-013 SHALL have port mon_accept  input  1  monitor takes the command when high with mon_valid.
REQ-014 SHALL have port mon_ready  input  1  monitor completion strobe (monitor_ready semantics).
REQ-015 SHALL have port mon_error  input  1  completion status; sampled only with mon_ready.
REQ-016 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-017 SHALL implement the FSM IDLE -> ISSUE -> WAIT -> DONE -> IDLE; all outputs registered.
REQ-018 In IDLE with req != 0, SHALL select the winner round-robin, starting the search at ptr, ptr+1, ... modulo 4; ptr resets to 0.
REQ-019 On selection SHALL, in the next cycle: gnt[w]=1, mon_cmd=req_cmd slice w, mon_sel=w, mon_valid=1, state=ISSUE; ptr=(w+1) mod 4.
REQ-020 SHALL NOT grant a requester whose req bit is low in the IDLE sampling cycle; a req dropped before grant is lost without side effect.
REQ-021 In ISSUE, mon_valid, mon_cmd and mon_sel SHALL stay stable until mon_accept=1; in that cycle mon_valid falls next cycle and state=WAIT.
REQ-022 ISSUE has no timeout; mon_accept never arriving holds ISSUE indefinitely.
REQ-023 On entering WAIT, a counter SHALL clear to 0 and increment each WAIT cycle.
REQ-024 In WAIT with mon_ready=1, SHALL go to DONE and latch status = mon_error.
REQ-025 In WAIT with mon_ready=0 and counter = TIMEOUT-1, SHALL go to DONE with status = error.
REQ-026 If mon_ready=1 in the timeout cycle, mon_ready SHALL win and status = mon_error.
REQ-027 mon_ready or mon_accept outside the state that samples them SHALL be ignored.
REQ-028 In DONE, SHALL drive done[mon_sel]=1 and err[mon_sel]=status for exactly one cycle, then go to IDLE.
REQ-029 Minimum turnaround SHALL be: req sampled in cycle 0, gnt in cycle 1, mon_accept in cycle 1, mon_ready in cycle 2, done in cycle 3, next gnt in cycle 5 at the earliest.
REQ-030 Requests arriving while busy=1 SHALL wait; no queueing beyond the level req.
REQ-031 mon_cmd and mon_sel SHALL hold their last value in IDLE.

Reset
REQ-032 With reset=1 at a rising edge: state=IDLE, ptr=0, counter=0, gnt=done=err=0, mon_valid=0, mon_cmd=0, mon_sel=0, busy=0.
REQ-033 Reset in any state SHALL abort the operation with no done/err pulse; reset has priority over every other input.

Verification
REQ-034 Only req=4'b0100 with cmd 0x2A_5555_AAAA, mon_accept=1, mon_ready=1 one cycle later -> gnt=0100 in cycle 1, mon_cmd=0x2A_5555_AAAA, done=0100 and err=0000 in cycle 3.
REQ-035 req=4'b1111 held through 4 transactions after reset -> gnt order 0001, 0010, 0100, 1000.
REQ-036 Grant to requester 1; mon_ready is never asserted with TIMEOUT=8 -> done=err=0010 eight cycles after entry to WAIT.
REQ-037 mon_ready=1 and mon_error=1 in the timeout cycle -> err=1; repeat with mon_error=0 -> err=0.
REQ-038 mon_accept held low for 5 cycles in ISSUE -> mon_valid, mon_cmd and mon_sel are stable for all 5 cycles and no counter activity occurs.
REQ-039 Reset asserted in WAIT -> no done/err pulse, busy=0 next cycle, and the next grant with req=1111 goes to requester 0.
